// File: rtl/trdb_pkg.sv
// ---------------------------------------------------------------------------
// trdb_pkg: shared constants and types for the trace debugger merge path.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package trdb_pkg;

    localparam int TRDB_XLEN  = 32;
    localparam int TRDB_DEPTH = 8;
    localparam int TRDB_MAX_CHAN_W = 3;

    typedef struct packed {
        logic [TRDB_MAX_CHAN_W-1:0] chan;
        logic [TRDB_XLEN-1:0]       word;
    } trdb_pkt_t;

    // Channel index width; a single channel still needs one bit of port.
    function automatic int trdb_chan_width(input int nchan);
        return (nchan > 1) ? $clog2(nchan) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trdb_sync_fifo.sv
// ---------------------------------------------------------------------------
// trdb_sync_fifo: show-ahead synchronous FIFO; push into a full FIFO is
// accepted when a pop happens in the same cycle. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trdb_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/trdb_trace_mux.sv
// ---------------------------------------------------------------------------
// trdb_trace_mux: merges per-hart trace word streams into one registered
// output with round-robin arbitration and per-channel drop accounting. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trdb_trace_mux
    import trdb_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int XLEN  = TRDB_XLEN,
    parameter int DEPTH = TRDB_DEPTH,
    parameter int CNTW  = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NCHAN*XLEN-1:0]               word_i,
    input  logic [NCHAN-1:0]                    word_valid_i,
    input  logic [NCHAN-1:0]                    chan_en_i,
    input  logic                                flush_i,
    input  logic                                clr_i,
    output logic [XLEN-1:0]                     word_o,
    output logic [trdb_chan_width(NCHAN)-1:0]   chan_o,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [NCHAN-1:0]                    overflow_o,
    output logic [NCHAN*CNTW-1:0]               drop_cnt_o
);

    localparam int CW = trdb_chan_width(NCHAN);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [NCHAN-1:0] push;
    logic [NCHAN-1:0] pop;
    logic [NCHAN-1:0] full;
    logic [NCHAN-1:0] empty;
    logic [NCHAN-1:0] drop;
    logic [XLEN-1:0]  head [NCHAN];

    logic [CW-1:0]    rr;
    logic [CW-1:0]    sel;
    logic [CW-1:0]    idx;
    logic [XLEN-1:0]  sel_word;
    logic             any;
    logic             load;

    assign load = !valid_o || ready_i;

    generate
        for (genvar c = 0; c < NCHAN; c++) begin : g_chan
            logic [CNTW-1:0] cnt;
            logic            ovf;

            assign push[c] = word_valid_i[c] && chan_en_i[c] && !flush_i;
            assign drop[c] = push[c] && full[c] && !pop[c];

            trdb_sync_fifo #(
                .WIDTH (XLEN),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .flush_i (flush_i),
                .push_i  (push[c]),
                .data_i  (word_i[c*XLEN +: XLEN]),
                .pop_i   (pop[c]),
                .data_o  (head[c]),
                .full_o  (full[c]),
                .empty_o (empty[c])
            );

            // A drop coinciding with a clear is still recorded.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt <= '0;
                    ovf <= 1'b0;
                end else if (clr_i) begin
                    cnt <= drop[c] ? CNTW'(1) : '0;
                    ovf <= drop[c];
                end else if (drop[c]) begin
                    ovf <= 1'b1;
                    if (cnt != CNT_MAX) cnt <= cnt + CNTW'(1);
                end
            end

            assign overflow_o[c]               = ovf;
            assign drop_cnt_o[c*CNTW +: CNTW]  = cnt;
        end
    endgenerate

    // Round-robin search beginning one past the last granted channel.
    always_comb begin
        any      = 1'b0;
        sel      = '0;
        sel_word = '0;
        idx      = '0;
        for (int k = 1; k <= NCHAN; k++) begin
            idx = CW'((int'(rr) + k) % NCHAN);
            if (!any && !empty[idx]) begin
                any      = 1'b1;
                sel      = idx;
                sel_word = head[idx];
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int c = 0; c < NCHAN; c++) begin
            pop[c] = load && any && !flush_i && (sel == CW'(c));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_o  <= '0;
            chan_o  <= '0;
            valid_o <= 1'b0;
            rr      <= CW'(NCHAN - 1);
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (load) begin
            valid_o <= any;
            if (any) begin
                word_o <= sel_word;
                chan_o <= sel;
                rr     <= sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/trdb_trace_mux.md
TRDB_TRACE_MUX -- requirements
Module: trdb_trace_mux

Interface
REQ-001 Parameter NCHAN, default 4: number of trace_debugger instances (harts) merged; legal 1..8.
REQ-002 Parameter XLEN, default 32: width of one packet word.
REQ-003 Parameter DEPTH, default 8: per-channel buffer depth in words; power of two, >=2.
REQ-004 Parameter CNTW, default 16: width of each per-channel drop counter.
REQ-005 clk_i  input  1  clock; all state changes on its rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 word_i  input  NCHAN*XLEN  packet words; channel c occupies bits [c*XLEN +: XLEN].
REQ-008 word_valid_i  input  NCHAN  per-channel word strobe; no backpressure toward the sources.
REQ-009 chan_en_i  input  NCHAN  per-channel enable; 0 ignores that channel's strobes.
REQ-010 flush_i  input  1  synchronous discard of all buffered and output-staged words.
REQ-011 clr_i  input  1  synchronous clear of drop counters and overflow flags.
REQ-012 word_o  output  XLEN  merged output word.
REQ-013 chan_o  output  max(1,$clog2(NCHAN))  source channel of word_o.
REQ-014 valid_o  output  1  word_o/chan_o valid.
REQ-015 ready_i  input  1  sink accepts; transfer when valid_o && ready_i at a rising edge.
REQ-016 overflow_o  output  NCHAN  sticky per-channel "words lost" flag.
REQ-017 drop_cnt_o  output  NCHAN*CNTW  per-channel count of lost words.

Function
REQ-018 Push: word_valid_i[c] && chan_en_i[c] && !flush_i writes word_i slice c into FIFO c at the edge.
REQ-019 Push to a full FIFO c with no pop of c in that cycle is dropped: overflow_o[c] set, drop counter c incremented.
REQ-020 Push to a full FIFO c with a simultaneous pop of c is accepted; no drop.
REQ-021 Drop counters saturate at 2^CNTW-1; no wrap.
REQ-022 Output stage: one register (word_o, chan_o, valid_o); it loads when empty or when transferring (valid_o && ready_i).
REQ-023 Load selects one non-empty FIFO by round-robin; search starts at last granted channel + 1, modulo NCHAN.
REQ-024 The selected FIFO is popped in the same cycle as the load; only one pop per cycle.
REQ-025 Latency: word pushed at edge E into an empty system appears with valid_o high after edge E+1.
REQ-026 Throughput: one word per cycle while ready_i is held high and any FIFO is non-empty.
REQ-027 While valid_o && !ready_i, word_o and chan_o are stable and no FIFO is popped.
REQ-028 Per-channel order is preserved; no word is duplicated.
REQ-029 flush_i: all FIFOs emptied, valid_o cleared at the edge; same-cycle pushes discarded and not counted; round-robin pointer unchanged.
REQ-030 clr_i: counters and overflow_o cleared; a same-cycle drop leaves counter = 1 and flag = 1 (drop wins).
REQ-031 NCHAN=1: arbiter degenerates; chan_o constant 0.

Reset
REQ-032 Reset: FIFOs empty, valid_o=0, word_o=0, chan_o=0, overflow_o=0, drop_cnt_o=0, round-robin pointer = NCHAN-1 (channel 0 wins first).
REQ-033 Reset deassertion mid-stream: no output transfer before the first push after reset.

Structure
REQ-034 The shared trdb_pkg holds the default XLEN and DEPTH constants and a struct typedef for {chan, word}.
REQ-035 Sub-module trdb_sync_fifo (parametrised width/depth; push, pop, full, empty) is instantiated NCHAN times.
REQ-036 All registers are in clk_i/rst_ni domain; there are no combinational paths from ready_i to word_o.

Verification
REQ-037 NCHAN=4, ch0 pushes 0xA0..0xA3 on consecutive cycles, ready_i=1 -> valid_o from cycle 2, words A0..A3 in order, chan_o=0.
REQ-038 All 4 channels push one word in the same cycle (0x10,0x11,0x12,0x13), ready_i=1 -> output order ch0,ch1,ch2,ch3; next simultaneous burst also starts at ch0.
REQ-039 DEPTH=8, ready_i=0, ch2 pushes 11 words -> 1 word staged on output, 8 buffered, 2 dropped; drop_cnt ch2=2, overflow_o=4'b0100.
REQ-040 FIFO full, push and pop of the same channel in the same cycle -> no drop, occupancy unchanged.
REQ-041 flush_i with 5 words buffered and valid_o=1 -> next cycle valid_o=0, all FIFOs empty, counters unchanged.
REQ-042 CNTW=4, 20 drops on ch1 -> drop_cnt ch1=15; clr_i with a simultaneous drop -> count=1, overflow_o[1]=1.
